// File: rtl/dualportram_ctl_if.sv
// Port bundle for dualportram_ctl: two independent read/write ports plus status.
//   a/wra/rda/addrs_a   : port A write data, write enable, read enable, address
//   out_a/valid_a       : port A read data and read-data-valid pulse
//   b/wrb/rdb/addrs_b   : port B write data, write enable, read enable, address
//   out_b/valid_b       : port B read data and read-data-valid pulse
//   collision           : both ports wrote the same address on the previous edge
//   init_busy           : memory clear in progress
interface dualportram_ctl_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) ();
    logic [DATA_W-1:0] a;
    logic              wra;
    logic              rda;
    logic [ADDR_W-1:0] addrs_a;
    logic [DATA_W-1:0] out_a;
    logic              valid_a;
    logic [DATA_W-1:0] b;
    logic              wrb;
    logic              rdb;
    logic [ADDR_W-1:0] addrs_b;
    logic [DATA_W-1:0] out_b;
    logic              valid_b;
    logic              collision;
    logic              init_busy;

    modport master (
        output a, wra, rda, addrs_a, b, wrb, rdb, addrs_b,
        input  out_a, valid_a, out_b, valid_b, collision, init_busy
    );

    modport slave (
        input  a, wra, rda, addrs_a, b, wrb, rdb, addrs_b,
        output out_a, valid_a, out_b, valid_b, collision, init_busy
    );
endinterface

// File: rtl/dualportram_ctl.sv
// Parametrised true dual-port synchronous RAM with hardware clear after reset.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; restarts the clear sequence
//   bus  : dualportram_ctl_if slave modport (both ports, collision, init_busy)
// Read latency is RD_LAT (1 or 2) edges; RDW_MODE selects old (0) or new (1)
// data for a same-port read and write to the same address on one edge.
module dualportram_ctl #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned RDW_MODE = 0
) (
    input logic              clk,
    input logic              rst,
    dualportram_ctl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [ADDR_W-1:0] clr_addr;
    logic              init_busy_q;
    logic              coll_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic run;
    logic same_addr;
    logic b_write_ok;
    assign run        = (state_q == ST_RUN);
    assign same_addr  = (bus.addrs_a == bus.addrs_b);
    // Port A wins a same-address write-write collision.
    assign b_write_ok = bus.wrb && !(bus.wra && same_addr);

    // Next-state logic: leave INIT once the last entry has been cleared.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: if (clr_addr == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    // State, clear pointer and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            clr_addr    <= '0;
            init_busy_q <= 1'b1;
            coll_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_busy_q <= (state_d == ST_INIT);
            coll_q      <= run && bus.wra && bus.wrb && same_addr;
            if (state_q == ST_INIT) clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    // Storage array: cleared during INIT, written by the ports in RUN.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (!run) begin
                mem[clr_addr] <= '0;
            end else begin
                if (b_write_ok) mem[bus.addrs_b] <= bus.b;
                if (bus.wra)    mem[bus.addrs_a] <= bus.a;
            end
        end
    end

    // First read stage; cross-port writes never bypass into a read.
    logic [DATA_W-1:0] d1_a, d1_b;
    logic              v1_a, v1_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_a <= '0;
            d1_b <= '0;
            v1_a <= 1'b0;
            v1_b <= 1'b0;
        end else begin
            v1_a <= run && bus.rda;
            v1_b <= run && bus.rdb;
            if (run && bus.rda) begin
                d1_a <= ((RDW_MODE == 1) && bus.wra) ? bus.a : mem[bus.addrs_a];
            end
            if (run && bus.rdb) begin
                d1_b <= ((RDW_MODE == 1) && b_write_ok) ? bus.b : mem[bus.addrs_b];
            end
        end
    end

    // Optional second output stage keeps data and valid aligned.
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] d2_a, d2_b;
            logic              v2_a, v2_b;
            always_ff @(posedge clk) begin
                if (rst) begin
                    d2_a <= '0;
                    d2_b <= '0;
                    v2_a <= 1'b0;
                    v2_b <= 1'b0;
                end else begin
                    v2_a <= v1_a;
                    v2_b <= v1_b;
                    if (v1_a) d2_a <= d1_a;
                    if (v1_b) d2_b <= d1_b;
                end
            end
            assign bus.out_a   = d2_a;
            assign bus.out_b   = d2_b;
            assign bus.valid_a = v2_a;
            assign bus.valid_b = v2_b;
        end else begin : g_lat1
            assign bus.out_a   = d1_a;
            assign bus.out_b   = d1_b;
            assign bus.valid_a = v1_a;
            assign bus.valid_b = v1_b;
        end
    endgenerate

    assign bus.collision = coll_q;
    assign bus.init_busy = init_busy_q;
endmodule

// File: tb/tb_dualportram_ctl.sv
// Scoreboard bench for dualportram_ctl. Two instances share one stimulus:
// dut0 (RD_LAT=1, read-first) and dut1 (RD_LAT=2, write-first). A reference
// model of the memory predicts read data, due cycle, busy and collision.
module tb_dualportram_ctl;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    typedef struct {
        int   edge_n;
        logic busy;
        logic coll;
        logic rst;
    } flag_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] a, b;
    logic              wra, rda, wrb, rdb;
    logic [ADDR_W-1:0] aa, ab;
    int                cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dualportram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if0 ();
    dualportram_ctl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if1 ();

    assign if0.a = a;   assign if0.wra = wra; assign if0.rda = rda; assign if0.addrs_a = aa;
    assign if0.b = b;   assign if0.wrb = wrb; assign if0.rdb = rdb; assign if0.addrs_b = ab;
    assign if1.a = a;   assign if1.wra = wra; assign if1.rda = rda; assign if1.addrs_a = aa;
    assign if1.b = b;   assign if1.wrb = wrb; assign if1.rdb = rdb; assign if1.addrs_b = ab;

    dualportram_ctl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(1), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave));
    dualportram_ctl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(2), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave));

    // Index: 0 = dut0 A, 1 = dut0 B, 2 = dut1 A, 3 = dut1 B
    logic              vld [4];
    logic [DATA_W-1:0] dat [4];
    assign vld[0] = if0.valid_a; assign dat[0] = if0.out_a;
    assign vld[1] = if0.valid_b; assign dat[1] = if0.out_b;
    assign vld[2] = if1.valid_a; assign dat[2] = if1.out_a;
    assign vld[3] = if1.valid_b; assign dat[3] = if1.out_b;

    exp_t  sbq [4][$];
    flag_t fq[$];

    logic [DATA_W-1:0] mem_m [DEPTH];
    int                init_left = 0;
    int                checks = 0;
    int                passes = 0;

    function automatic void chk(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s[%0d] cyc=%0d actual=%0h required=%0h", name, idx, cyc, act, exp);
    endfunction

    // One clock of stimulus; model predicts the effect of the coming edge.
    task automatic step(input logic r, input logic wa, input logic ra_, input logic [ADDR_W-1:0] xa,
                        input logic [DATA_W-1:0] da, input logic wb, input logic rb_,
                        input logic [ADDR_W-1:0] xb, input logic [DATA_W-1:0] db);
        int                e;
        flag_t             f;
        exp_t              x;
        logic [DATA_W-1:0] old_a, old_b;
        rst = r; wra = wa; rda = ra_; aa = xa; a = da;
        wrb = wb; rdb = rb_; ab = xb; b = db;
        e = cyc + 1;
        f.edge_n = e; f.rst = r; f.coll = 1'b0; f.busy = 1'b0;
        if (r) begin
            init_left = DEPTH;
            for (int d = 0; d < 4; d++) sbq[d].delete();
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
            f.busy = 1'b1;
        end else if (init_left > 0) begin
            init_left--;
            f.busy = (init_left > 0);
        end else begin
            old_a  = mem_m[xa];
            old_b  = mem_m[xb];
            f.coll = wa && wb && (xa == xb);
            if (ra_) begin
                x.data = old_a;             x.due = e;     sbq[0].push_back(x);
                x.data = wa ? da : old_a;   x.due = e + 1; sbq[2].push_back(x);
            end
            if (rb_) begin
                x.data = old_b;                       x.due = e;     sbq[1].push_back(x);
                x.data = (wb && !f.coll) ? db : old_b; x.due = e + 1; sbq[3].push_back(x);
            end
            if (wb) mem_m[xb] = db;
            if (wa) mem_m[xa] = da;
        end
        fq.push_back(f);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++)
            step(0, 0, 1, ADDR_W'(i), '0, 0, 1, ADDR_W'(DEPTH - 1 - i), '0);
    endtask

    // Monitor: compare status flags every edge and pop read results on valid.
    initial begin
        flag_t f;
        exp_t  x;
        forever begin
            @(posedge clk);
            #1;
            if (fq.size() > 0 && fq[0].edge_n == cyc) begin
                f = fq.pop_front();
                chk("init_busy0", 0, longint'(if0.init_busy), longint'(f.busy));
                chk("init_busy1", 1, longint'(if1.init_busy), longint'(f.busy));
                chk("collision0", 0, longint'(if0.collision), longint'(f.coll));
                chk("collision1", 1, longint'(if1.collision), longint'(f.coll));
                if (f.rst) begin
                    for (int d = 0; d < 4; d++) begin
                        chk("rst_out", d, longint'(dat[d]), 0);
                        chk("rst_valid", d, longint'(vld[d]), 0);
                    end
                end
            end
            for (int d = 0; d < 4; d++) begin
                if (vld[d]) begin
                    if (sbq[d].size() == 0) begin
                        chk("unexpected_valid", d, 1, 0);
                    end else begin
                        x = sbq[d].pop_front();
                        chk("rd_data", d, longint'(dat[d]), longint'(x.data));
                        chk("rd_cycle", d, longint'(cyc), longint'(x.due));
                    end
                end else if (sbq[d].size() > 0 && sbq[d][0].due <= cyc) begin
                    x = sbq[d].pop_front();
                    chk("missing_valid", d, 0, 1);
                end
            end
        end
    end

    initial begin
        // Reset for two cycles, then writes/reads during INIT are ignored.
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 1, ADDR_W'(i), 8'hFF, 1, 1, ADDR_W'(i), 8'hEE);
        read_all();

        // Basic write/read.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, ADDR_W'(i), 8'h18, 0, 0, '0, '0);
        step(0, 0, 0, '0, '0, 1, 0, 3'd5, 8'h14);
        read_all();

        // Write-write collision, then distinct addresses.
        step(0, 1, 0, 3'd3, 8'hAA, 1, 0, 3'd3, 8'h55);
        step(0, 0, 1, 3'd3, '0, 0, 1, 3'd3, '0);
        step(0, 1, 0, 3'd3, 8'hAA, 1, 0, 3'd4, 8'h55);
        step(0, 0, 1, 3'd4, '0, 0, 1, 3'd3, '0);

        // Read-during-write on address 2, same port and cross port.
        step(0, 1, 0, 3'd2, 8'h11, 0, 0, '0, '0);
        step(0, 1, 1, 3'd2, 8'h22, 0, 1, 3'd2, '0);
        step(0, 0, 0, '0, '0, 1, 1, 3'd6, 8'h33);
        step(0, 0, 1, 3'd6, '0, 0, 0, '0, '0);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) step(0, 0, 1, ADDR_W'(i), '0, 0, 0, '0, '0);
        idle(3);

        // Randomised traffic over a small address range to provoke collisions.
        for (int i = 0; i < 300; i++)
            step(0, 1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 3)), 8'($urandom),
                 1'($urandom), 1'($urandom), ADDR_W'($urandom_range(0, 3)), 8'($urandom));

        // Reset with reads in flight, then reset during INIT.
        step(0, 0, 1, 3'd1, '0, 0, 1, 3'd2, '0);
        step(1, 0, 1, 3'd1, '0, 0, 1, 3'd2, '0);
        idle(3);
        step(1, 0, 0, '0, '0, 0, 0, '0, '0);
        for (int i = 0; i < DEPTH; i++)
            step(0, 1, 0, ADDR_W'(i), 8'h5A, 0, 1, ADDR_W'(i), '0);
        read_all();
        idle(4);

        for (int d = 0; d < 4; d++) chk("drain", d, longint'(sbq[d].size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
